pe_multi_weight: RTL

Next-generation systolic-array processing element for the matmul accelerator.
- Stores up to NUM_WEIGHTS stationary weights and applies them round-robin to incoming activations, so one PE array computes NUM_WEIGHTS interleaved tiles.
- Computes part_prod_out = part_prod_in + weight*activation with a widened, optionally saturating accumulator.
- Activations and surplus weights move east on the message channel; partial products move south. Every channel uses a val/rdy handshake.

---
 rtl/matmul_pkg.sv | 28 ++
 rtl/pe_weight_bank.sv | 62 ++++++
 rtl/pe_multi_weight.sv | 122 ++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul PE family: message kinds and the
// widened, optionally saturating accumulate.
package matmul_pkg;

   localparam int KIND_W = 2;

   typedef enum logic [KIND_W-1:0] {
      KIND_ACT    = 2'd0,
      KIND_WEIGHT = 2'd1,
      KIND_CLEAR  = 2'd2
   } msg_kind_e;

   // One extra bit of headroom detects overflow of an acc_w-bit sum.
   // Valid for acc_w <= 63.
   function automatic logic [63:0] sat_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int          acc_w,
                                           input bit          sat_en);
      logic [64:0] sum;
      logic [64:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (65'd1 << acc_w) - 65'd1;
      if (sat_en && (sum > lim)) sum = lim;
      sum = sum & lim;
      return sum[63:0];
   endfunction

endpackage

// File: rtl/pe_weight_bank.sv
// Stationary weight store: circular write pointer for loading, read pointer
// that rotates over the weights actually held.
module pe_weight_bank
   import matmul_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int NUM_WEIGHTS = 4,
   parameter int CNT_W       = $clog2(NUM_WEIGHTS+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              clear,
   input  logic              advance,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;

   logic [DATA_W-1:0] bank [NUM_WEIGHTS];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   assign full    = (count == CNT_W'(NUM_WEIGHTS));
   assign empty   = (count == '0);
   // An empty bank contributes a zero weight so part_prod passes through.
   assign rd_data = empty ? '0 : bank[rd_ptr];

   // Pointer/count bookkeeping; clear wins over everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= (wr_ptr == PTR_W'(NUM_WEIGHTS-1)) ? '0 : wr_ptr + PTR_W'(1);
            count  <= count + CNT_W'(1);
         end
         if (advance && !empty)
            rd_ptr <= ((CNT_W'(rd_ptr) + CNT_W'(1)) == count) ? '0 : rd_ptr + PTR_W'(1);
      end
   end

   // Weight storage; reset wipes stale weights so nothing survives a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WEIGHTS; i++) bank[i] <= '0;
      end else if (push && !full && !clear) begin
         bank[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/pe_multi_weight.sv
// Systolic PE with a multi-weight stationary bank. Activations and surplus
// weights flow east, partial products flow south, all via val/rdy.
module pe_multi_weight
   import matmul_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ACC_W       = 16,
   parameter int NUM_WEIGHTS = 4,
   parameter int SAT_EN      = 1
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [ACC_W-1:0]                 i_part_prod_recv,
   input  logic                             i_part_prod_recv_val,
   output logic                             o_part_prod_recv_rdy,
   input  logic [KIND_W+DATA_W-1:0]         i_msg_recv,
   input  logic                             i_msg_recv_val,
   output logic                             o_msg_recv_rdy,
   output logic [ACC_W-1:0]                 o_part_prod_send,
   output logic                             o_part_prod_send_val,
   input  logic                             i_part_prod_send_rdy,
   output logic [KIND_W+DATA_W-1:0]         o_msg_send,
   output logic                             o_msg_send_val,
   input  logic                             i_msg_send_rdy,
   output logic [$clog2(NUM_WEIGHTS+1)-1:0] o_weight_count
);

   localparam int CNT_W = $clog2(NUM_WEIGHTS+1);

   typedef struct packed {
      logic [KIND_W-1:0] kind;
      logic [DATA_W-1:0] data;
   } msg_t;

   msg_t              msg_in;
   logic              is_act, is_weight, is_clear;
   logic              msg_free, pp_free;
   logic              act_fire, msg_acc, fwd;
   logic              push, clear, advance;
   logic              full, empty;
   logic [DATA_W-1:0] weight;
   logic [2*DATA_W-1:0] prod;
   logic [63:0]       sum64;
   logic [ACC_W-1:0]  result;

   assign msg_in    = msg_t'(i_msg_recv);
   assign is_act    = (msg_in.kind == KIND_ACT);
   assign is_weight = (msg_in.kind == KIND_WEIGHT);
   assign is_clear  = (msg_in.kind == KIND_CLEAR);

   // Output slot can take new data if empty or draining this edge.
   assign msg_free = !o_msg_send_val | i_msg_send_rdy;
   assign pp_free  = !o_part_prod_send_val | i_part_prod_send_rdy;

   // ACT consumes both inputs atomically, so both rdys share one condition.
   assign act_fire = is_act & i_msg_recv_val & i_part_prod_recv_val & msg_free & pp_free;

   // Per-kind west readiness; reserved kind is always swallowed.
   always_comb begin
      o_msg_recv_rdy = 1'b1;
      if (is_act)                 o_msg_recv_rdy = act_fire;
      else if (is_weight && full) o_msg_recv_rdy = msg_free;
      else if (is_clear)          o_msg_recv_rdy = msg_free;
      o_msg_recv_rdy = o_msg_recv_rdy & i_rst_n;
   end

   assign o_part_prod_recv_rdy = act_fire & i_rst_n;

   assign msg_acc = i_msg_recv_val & o_msg_recv_rdy;
   assign fwd     = msg_acc & (is_act | is_clear | (is_weight & full));
   assign push    = msg_acc & is_weight & !full;
   assign clear   = msg_acc & is_clear;
   assign advance = msg_acc & is_act;

   pe_weight_bank #(
      .DATA_W      (DATA_W),
      .NUM_WEIGHTS (NUM_WEIGHTS),
      .CNT_W       (CNT_W)
   ) u_bank (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .push      (push),
      .push_data (msg_in.data),
      .clear     (clear),
      .advance   (advance),
      .rd_data   (weight),
      .full      (full),
      .empty     (empty),
      .count     (o_weight_count)
   );

   assign prod   = weight * msg_in.data;
   assign sum64  = sat_add(64'(i_part_prod_recv), 64'(prod), ACC_W, SAT_EN != 0);
   assign result = sum64[ACC_W-1:0];

   // East output register: load on forward, otherwise drop valid once taken.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_msg_send_val <= 1'b0;
         o_msg_send     <= '0;
      end else if (fwd) begin
         o_msg_send_val <= 1'b1;
         o_msg_send     <= i_msg_recv;
      end else if (i_msg_send_rdy) begin
         o_msg_send_val <= 1'b0;
      end
   end

   // South output register: load the MAC result on ACT fire.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_part_prod_send_val <= 1'b0;
         o_part_prod_send     <= '0;
      end else if (act_fire) begin
         o_part_prod_send_val <= 1'b1;
         o_part_prod_send     <= result;
      end else if (i_part_prod_send_rdy) begin
         o_part_prod_send_val <= 1'b0;
      end
   end

endmodule
